// File: rtl/soc_fpga_temp_monitor_pkg.sv
// soc_fpga_temp_monitor_pkg: state encoding and widths shared by the temperature monitor
package soc_fpga_temp_monitor_pkg;
  localparam int TEMP_W = 8;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_NORMAL = 2'd1,
    ST_ALARM  = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;
endpackage

// File: rtl/soc_fpga_temp_monitor_sync.sv
// soc_fpga_temp_monitor_sync: two-flop synchronizer with async reset
module soc_fpga_temp_monitor_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_ff;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_ff <= '0;
    else r_ff <= {r_ff[0], i_d};
  assign o_q = r_ff[1];
endmodule

// File: rtl/soc_fpga_temp_monitor.sv
// soc_fpga_temp_monitor: sensor sampler with alarm hysteresis, error/timeout fault;
// defining SOC_FPGA_TEMP_MONITOR_AVG_EN adds a 4-sample moving average on TEMP_OUT.
module soc_fpga_temp_monitor
  import soc_fpga_temp_monitor_pkg::*;
#(
  parameter int ALARM_SET      = 100,
  parameter int ALARM_CLEAR    = 90,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [TEMP_W-1:0] TEMPERATURE,
  input  logic              VALID,
  input  logic              ERROR,
  output logic [TEMP_W-1:0] TEMP_OUT,
  output logic              TEMP_VALID,
  output logic              ALARM,
  output logic              FAULT,
  output logic [1:0]        STATE
);
  if (ALARM_CLEAR >= ALARM_SET) begin : g_bad_thresholds
    $error("ALARM_CLEAR must be below ALARM_SET");
  end
  localparam logic [TEMP_W-1:0] L_SET   = TEMP_W'(ALARM_SET);
  localparam logic [TEMP_W-1:0] L_CLR   = TEMP_W'(ALARM_CLEAR);
  localparam logic [CNT_W-1:0]  L_TO_M1 = CNT_W'(TIMEOUT_CYCLES - 1);
  logic              w_valid_s, w_err_s, w_acc, w_first;
  logic              r_prev, r_armed, r_tv;
  logic [1:0]        r_live;
  logic [CNT_W-1:0]  r_cnt;
  logic [TEMP_W-1:0] r_temp, w_temp_nxt;
  state_t            r_state, w_state_nxt;
  soc_fpga_temp_monitor_sync u_sync_valid (.clk(CLK), .rst(RESET), .i_d(VALID), .o_q(w_valid_s));
  soc_fpga_temp_monitor_sync u_sync_err   (.clk(CLK), .rst(RESET), .i_d(ERROR), .o_q(w_err_s));
  // r_armed blocks a VALID that was already high when reset released
  assign w_acc   = w_valid_s & ~r_prev & r_armed & ~w_err_s;
  assign w_first = r_state == ST_INIT || r_state == ST_FAULT;
`ifdef SOC_FPGA_TEMP_MONITOR_AVG_EN
  // three stored samples plus the incoming one form the 4-entry window
  logic [TEMP_W-1:0] r_win [3];
  logic [9:0]        w_sum;
  assign w_sum = w_first ? {TEMPERATURE, 2'b00}
                         : 10'(r_win[0]) + 10'(r_win[1]) + 10'(r_win[2]) + 10'(TEMPERATURE);
  assign w_temp_nxt = w_sum[9:2];
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) r_win <= '{default: '0};
    else if (w_acc) r_win <= w_first ? '{TEMPERATURE, TEMPERATURE, TEMPERATURE}
                                     : '{TEMPERATURE, r_win[0], r_win[1]};
`else
  assign w_temp_nxt = TEMPERATURE;
`endif
  always_comb begin
    w_state_nxt = r_state;
    if (w_err_s) w_state_nxt = ST_FAULT;
    else if (w_acc)
      w_state_nxt = (w_first || r_state == ST_NORMAL) ? (w_temp_nxt >= L_SET ? ST_ALARM : ST_NORMAL)
                                                      : (w_temp_nxt <= L_CLR ? ST_NORMAL : ST_ALARM);
    else if (!w_first && r_cnt >= L_TO_M1) w_state_nxt = ST_FAULT;
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      r_state <= ST_INIT;
      r_temp  <= '0;
      r_tv    <= 1'b0;
      r_cnt   <= '0;
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      r_live  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tv    <= w_acc;
      if (w_acc) r_temp <= w_temp_nxt;
      r_cnt   <= (w_acc || w_first) ? '0 : (&r_cnt ? r_cnt : r_cnt + 1'b1);
      r_prev  <= w_valid_s;
      r_live  <= {r_live[0], 1'b1};
      r_armed <= r_armed | (r_live[1] & ~w_valid_s);
    end
  assign TEMP_OUT   = r_temp;
  assign TEMP_VALID = r_tv;
  assign ALARM      = r_state == ST_ALARM;
  assign FAULT      = r_state == ST_FAULT;
  assign STATE      = r_state;
endmodule

// File: tb/tb_soc_fpga_temp_monitor.sv
// tb_soc_fpga_temp_monitor: self-checking bench for soc_fpga_temp_monitor
module tb_soc_fpga_temp_monitor;
`ifdef SOC_FPGA_TEMP_MONITOR_AVG_EN
  localparam int P_SET = 90, P_CLR = 80;
`else
  localparam int P_SET = 100, P_CLR = 90;
`endif
  localparam int P_TO = 20;
  logic       CLK = 1'b0, RESET = 1'b1, VALID = 1'b0, ERROR = 1'b0;
  logic [7:0] TEMPERATURE = 8'd0;
  logic [7:0] TEMP_OUT;
  logic       TEMP_VALID, ALARM, FAULT;
  logic [1:0] STATE;
  int compared = 0, mismatched = 0, cyc = 0;
  soc_fpga_temp_monitor #(.ALARM_SET(P_SET), .ALARM_CLEAR(P_CLR), .TIMEOUT_CYCLES(P_TO)) dut (
    .CLK(CLK), .RESET(RESET), .TEMPERATURE(TEMPERATURE), .VALID(VALID), .ERROR(ERROR),
    .TEMP_OUT(TEMP_OUT), .TEMP_VALID(TEMP_VALID), .ALARM(ALARM), .FAULT(FAULT), .STATE(STATE)
  );
  always #5 CLK = ~CLK;
  int   m_state = 0, m_temp = 0, m_tv = 0, m_cnt = 0, n = 0;
  int   m_win[4] = '{0, 0, 0, 0};
  bit   vq[$], eq[$];
  // reference: VALID/ERROR seen at edge k act at edge k+2; a rise needs a low seen after reset
  always @(posedge CLK or posedge RESET) begin
    int sz, cnt1, acc, err, first, was_first;
    if (RESET) begin
      m_state = 0; m_temp = 0; m_tv = 0; m_cnt = 0; n = 0;
      m_win = '{0, 0, 0, 0};
      vq.delete(); eq.delete();
    end else begin
      vq.push_back(VALID); eq.push_back(ERROR); n++;
      if (vq.size() > 4) begin void'(vq.pop_front()); void'(eq.pop_front()); end
      sz = vq.size();
      err = (sz >= 3 && eq[sz-3]) ? 1 : 0;
      acc = (n >= 4 && vq[sz-3] && !vq[sz-4] && err == 0) ? 1 : 0;
      was_first = (m_state == 0 || m_state == 3) ? 1 : 0;
      cnt1 = m_cnt >= 65535 ? 65535 : m_cnt + 1;
      m_tv = acc;
      if (err != 0) m_state = 3;
      else if (acc != 0) begin
        first = was_first;
`ifdef SOC_FPGA_TEMP_MONITOR_AVG_EN
        if (first != 0) m_win = '{int'(TEMPERATURE), int'(TEMPERATURE), int'(TEMPERATURE), int'(TEMPERATURE)};
        else begin m_win[3] = m_win[2]; m_win[2] = m_win[1]; m_win[1] = m_win[0]; m_win[0] = int'(TEMPERATURE); end
        m_temp = (m_win[0] + m_win[1] + m_win[2] + m_win[3]) / 4;
`else
        m_temp = int'(TEMPERATURE);
`endif
        if (first != 0 || m_state == 1) m_state = m_temp >= P_SET ? 2 : 1;
        else m_state = m_temp <= P_CLR ? 1 : 2;
      end else if (was_first == 0 && cnt1 >= P_TO) m_state = 3;
      m_cnt = (acc != 0 || was_first != 0) ? 0 : cnt1;
    end
  end
  always @(posedge CLK) begin
    #1;
    cyc++;
    compared++;
    if (STATE !== 2'(m_state) || TEMP_OUT !== 8'(m_temp) || TEMP_VALID !== 1'(m_tv) ||
        ALARM !== (m_state == 2) || FAULT !== (m_state == 3)) begin
      mismatched++;
      $display("FAIL model cyc %0d: got st=%0d t=%0d tv=%0d al=%0d ft=%0d want st=%0d t=%0d tv=%0d",
               cyc, STATE, TEMP_OUT, TEMP_VALID, ALARM, FAULT, m_state, m_temp, m_tv);
    end
  end
  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic samp(input int t, input int est, input int etmp, input string nm);
    @(negedge CLK); TEMPERATURE = 8'(t); VALID = 1'b1;
    repeat (2) @(posedge CLK);
    #1 chk({nm, "_early"}, int'(TEMP_VALID), 0);
    @(posedge CLK);
    #1;
    chk({nm, "_tv"}, int'(TEMP_VALID), 1);
    chk({nm, "_temp"}, int'(TEMP_OUT), etmp);
    chk({nm, "_state"}, int'(STATE), est);
    @(negedge CLK) VALID = 1'b0;
  endtask
  task automatic gap(input int k);
    repeat (k) @(negedge CLK);
  endtask
  initial begin
    int seen, t, hold;
    #12;
    chk("rst_state", int'(STATE), 0);
    chk("rst_out", int'({TEMP_OUT, TEMP_VALID, ALARM, FAULT}), 0);
    @(negedge CLK) RESET = 1'b0;
    gap(5);
`ifdef SOC_FPGA_TEMP_MONITOR_AVG_EN
    for (int i = 0; i < 4; i++) begin samp(80, 1, 80, "avg80"); gap(3); end
    samp(120, 2, 90, "avg120");
    chk("avg_alarm", int'(ALARM), 1);
    gap(3);
`else
    samp(50, 1, 50, "s50");
    gap(3);
    samp(100, 2, 100, "s100");
    chk("s100_alarm", int'(ALARM), 1);
    gap(3);
    samp(95, 2, 95, "hys95");
    gap(3);
    samp(90, 1, 90, "hys90");
    chk("hys90_alarm", int'(ALARM), 0);
    gap(2);
    ERROR = 1'b1;
    gap(3);
    chk("err_fault", int'(FAULT), 1);
    chk("err_hold", int'(TEMP_OUT), 90);
    TEMPERATURE = 8'd33; VALID = 1'b1;
    seen = 0;
    repeat (6) begin @(posedge CLK); #1 if (TEMP_VALID) seen++; end
    chk("err_no_tv", seen, 0);
    @(negedge CLK); ERROR = 1'b0; VALID = 1'b0;
    gap(4);
    chk("err_still_fault", int'(STATE), 3);
    samp(40, 1, 40, "to_s40");
    repeat (P_TO - 1) @(posedge CLK);
    #1 chk("to_before", int'(FAULT), 0);
    @(posedge CLK);
    #1 chk("to_fault", int'(FAULT), 1);
    gap(3);
    samp(40, 1, 40, "to_recover");
    gap(3);
    @(negedge CLK); TEMPERATURE = 8'd77; VALID = 1'b1;
    @(posedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("mid_rst_state", int'(STATE), 0);
    chk("mid_rst_out", int'({TEMP_OUT, TEMP_VALID, ALARM, FAULT}), 0);
    @(negedge CLK) RESET = 1'b0;
    seen = 0;
    repeat (8) begin @(posedge CLK); #1 if (TEMP_VALID) seen++; end
    chk("rst_no_tv", seen, 0);
    @(negedge CLK) VALID = 1'b0;
    gap(3);
    samp(60, 1, 60, "post_rst");
    gap(3);
`endif
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 9))
        0: begin ERROR = 1'b1; gap($urandom_range(1, 4)); ERROR = 1'b0; gap(2); end
        1: gap($urandom_range(15, 30));
        default: begin
          t = $urandom_range(0, 1) != 0 ? int'($urandom_range(0, 255)) : P_SET - 12 + int'($urandom_range(0, 24));
          hold = $urandom_range(1, 4);
          @(negedge CLK); TEMPERATURE = 8'(t); VALID = 1'b1;
          if ($urandom_range(0, 7) == 0) ERROR = 1'b1;
          gap(hold);
          VALID = 1'b0; ERROR = 1'b0;
          gap($urandom_range(3, 8));
        end
      endcase
    end
    gap(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/soc_fpga_temp_monitor.md
SOC_FPGA_TEMP_MONITOR -- requirements
Module: soc_fpga_temp_monitor

Interface
REQ-001 SHALL have parameter ALARM_SET, default 100, the alarm entry threshold in degrees C (unsigned 8-bit).
REQ-002 SHALL have parameter ALARM_CLEAR, default 90, the alarm exit threshold (hysteresis); ALARM_CLEAR < ALARM_SET is required, and elaboration SHALL fail otherwise.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000, the stale-sample limit in CLK cycles (1..65535).
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port TEMPERATURE, input, 8 bits: sensor reading, stable while VALID is high.
REQ-007 SHALL have port VALID, input, 1 bit: sensor data valid, asynchronous to CLK.
REQ-008 SHALL have port ERROR, input, 1 bit: sensor error flag, asynchronous to CLK.
REQ-009 SHALL have port TEMP_OUT, output, 8 bits: last accepted temperature, or the filtered value when averaging is enabled.
REQ-010 SHALL have port TEMP_VALID, output, 1 bit: one-cycle pulse when TEMP_OUT updates.
REQ-011 SHALL have port ALARM, output, 1 bit: high while the state is ALARM.
REQ-012 SHALL have port FAULT, output, 1 bit: high while the state is FAULT.
REQ-013 SHALL have port STATE, output, 2 bits: INIT=0, NORMAL=1, ALARM=2, FAULT=3.

Function
REQ-014 SHALL pass VALID and ERROR through two-flop synchronizers before any use.
REQ-015 SHALL accept a sample on the rising edge of synchronized VALID, only when synchronized ERROR is 0.
- TEMP_OUT updates, and TEMP_VALID pulses, on the third rising CLK edge after VALID rises.
- VALID held high yields exactly one sample.
REQ-016 SHALL make these state transitions:
- INIT to NORMAL on an accepted value < ALARM_SET.
- INIT to ALARM on an accepted value >= ALARM_SET.
- NORMAL to ALARM on an accepted value >= ALARM_SET.
- ALARM to NORMAL on an accepted value <= ALARM_CLEAR.
- In ALARM, values strictly between ALARM_CLEAR and ALARM_SET keep the state at ALARM.
REQ-017 SHALL enter FAULT from any state when synchronized ERROR is 1.
REQ-018 SHALL enter FAULT from NORMAL or ALARM when the timeout counter reaches TIMEOUT_CYCLES.
REQ-019 SHALL keep a 16-bit timeout counter that:
- clears on every accepted sample and in INIT/FAULT;
- increments in NORMAL/ALARM;
- saturates.
REQ-020 SHALL leave FAULT only on an accepted sample (which requires ERROR low), classifying that sample as from INIT (to NORMAL or ALARM).
REQ-021 SHALL resolve simultaneous events with this priority: ERROR, then accepted sample, then timeout (an accepted sample in the timeout cycle prevents FAULT).
REQ-022 SHALL compare thresholds against the value presented on TEMP_OUT.
REQ-023 SHALL hold TEMP_OUT unchanged while in FAULT.

Reset
REQ-024 SHALL, on RESET assertion and without waiting for a clock edge, set:
- STATE=INIT, TEMP_OUT=0, TEMP_VALID=0, ALARM=0, FAULT=0;
- synchronizers, edge detector, counter and averaging storage to 0.
REQ-025 SHALL, when RESET is asserted mid-sample, discard that sample; a VALID already high at deassertion is not accepted until it falls and rises again.

Configuration
REQ-026 SHALL compile in a 4-sample moving average when macro SOC_FPGA_TEMP_MONITOR_AVG_EN is defined:
- 10-bit sum, TEMP_OUT = sum >> 2 (truncated);
- the first sample accepted after INIT or FAULT preloads all four entries with that value;
- latency is unchanged from REQ-015.
REQ-027 SHALL, without SOC_FPGA_TEMP_MONITOR_AVG_EN, present the raw accepted TEMPERATURE on TEMP_OUT, with no averaging storage instantiated.

Structure
REQ-028 SHALL take its state encoding (2-bit enum) and width constants (TEMP_W=8, CNT_W=16) from package soc_fpga_temp_monitor_pkg.
REQ-029 SHALL instantiate sub-module soc_fpga_temp_monitor_sync (2-flop synchronizer, async reset) once each for VALID and ERROR.

Verification
REQ-030 SHALL cover raw mode: samples 50 then 100 -> STATE 0->1->2, ALARM=1 three CLK edges after the second VALID rise.
REQ-031 SHALL cover hysteresis: in ALARM, samples 95 then 90 -> STATE stays 2 after 95 and goes to 1 after 90.
REQ-032 SHALL cover ERROR: ERROR high for 3 cycles during NORMAL -> FAULT=1; TEMP_OUT holds; a VALID pulse while ERROR=1 gives no TEMP_VALID.
REQ-033 SHALL cover timeout: TIMEOUT_CYCLES=20, one sample of 40, then silence -> FAULT=1 once the counter reaches 20; next sample 40 -> STATE=1.
REQ-034 SHALL cover averaging (AVG_EN): samples 80,80,80,80 then 120 -> TEMP_OUT 80 then 90; ALARM_SET=90 -> ALARM=1.
REQ-035 SHALL cover reset: RESET asserted one cycle after VALID rises -> all outputs 0 immediately; no TEMP_VALID after release while VALID stays high.
